toggle_activity_monitor: RTL

TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

---
 rtl/toggle_activity_monitor_pkg.sv | 18 +
 rtl/toggle_sat_counter.sv | 31 +++
 rtl/toggle_activity_monitor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/toggle_activity_monitor_pkg.sv
// Shared types and constants for the toggle activity monitor: FSM state
// encoding and bit positions of the observed sub-circuit nets.
package toggle_activity_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam int IDX_N1 = 0;
  localparam int IDX_N2 = 1;
  localparam int IDX_N3 = 2;
  localparam int IDX_N4 = 3;
  localparam int IDX_N8 = 4;

endpackage

// File: rtl/toggle_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping so long windows never under-report activity.
module toggle_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear has priority, increments stop at the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/toggle_activity_monitor.sv
// Counts per-net toggles over a window of qualified samples; the first
// sample of a window only primes the previous-value register.
module toggle_activity_monitor
  import toggle_activity_monitor_pkg::*;
#(
  parameter int NETS  = 5,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIN_W-1:0]      win_len,
  input  logic                  sample_vld,
  input  logic [NETS-1:0]       sample,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NETS*CNT_W-1:0] res_cnt
);

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  state_e            state_s;
  logic [NETS-1:0]   prev_r;
  logic [WIN_W-1:0]  remaining_r;
  logic [WIN_W-1:0]  win_len_r;
  logic              busy_r;
  logic              res_valid_r;
  logic              clr_s;
  logic [NETS-1:0]   inc_s;

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_PRIME;
        else       state_s = ST_IDLE;
      end
      ST_PRIME: begin
        if (sample_vld) begin
          if (win_len_r == WIN_ZERO) state_s = ST_REPORT;
          else                       state_s = ST_COUNT;
        end else begin
          state_s = ST_PRIME;
        end
      end
      ST_COUNT: begin
        if (sample_vld && (remaining_r == WIN_ONE)) state_s = ST_REPORT;
        else                                        state_s = ST_COUNT;
      end
      ST_REPORT: begin
        if (res_ready) state_s = ST_IDLE;
        else           state_s = ST_REPORT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Counter controls: clear on accepted start, increment on toggles in COUNT.
  always_comb begin
    clr_s = 1'b0;
    inc_s = {NETS{1'b0}};
    if (state_r == ST_IDLE) begin
      clr_s = start;
    end else if ((state_r == ST_COUNT) && sample_vld) begin
      inc_s = sample ^ prev_r;
    end else begin
      inc_s = {NETS{1'b0}};
    end
  end

  // State and registered status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE);
      res_valid_r <= (state_s == ST_REPORT);
    end
  end

  // Window bookkeeping: latched length, remaining samples, previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len_r   <= WIN_ZERO;
      remaining_r <= WIN_ZERO;
      prev_r      <= {NETS{1'b0}};
    end else if (clr_s) begin
      win_len_r   <= win_len;
      remaining_r <= win_len;
      prev_r      <= {NETS{1'b0}};
    end else if ((state_r == ST_PRIME) && sample_vld) begin
      prev_r      <= sample;
    end else if ((state_r == ST_COUNT) && sample_vld) begin
      prev_r      <= sample;
      remaining_r <= remaining_r - WIN_ONE;
    end
  end

  for (genvar i = 0; i < NETS; i++) begin : g_cnt
    toggle_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_s),
      .inc   (inc_s[i]),
      .cnt   (res_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign busy      = busy_r;
  assign res_valid = res_valid_r;

endmodule
